// File: rtl/toast_ex_muldiv_stage.sv
// Toast execute stage: single-cycle ALU plus an iterative RV32M multiply/divide
// unit. M ops hold the upstream pipeline through EX_stall_o while they iterate.
//
// ALU control encoding:
//   0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA,
//   8 OR, 9 AND, 10 EQ (op1 == op2), 11 pass op2, others give 0.
// A non-zero ID_branch_op_i marks a conditional branch.
module toast_ex_muldiv_stage #(
  parameter int DATA_WIDTH = 32,
  parameter bit MD_ENABLE  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  flush_i,
  input  logic                  ID_md_en_i,
  input  logic [2:0]            ID_md_op_i,
  input  logic [3:0]            ID_alu_ctrl_i,
  input  logic [1:0]            ID_alu_source_sel_i,
  input  logic                  ID_jump_en_i,
  input  logic [1:0]            ID_branch_op_i,
  input  logic                  ID_branch_flag_i,
  input  logic [1:0]            forwardA_i,
  input  logic [1:0]            forwardB_i,
  input  logic [DATA_WIDTH-1:0] WB_rd_wr_data_i,
  input  logic [DATA_WIDTH-1:0] ID_pc_i,
  input  logic [DATA_WIDTH-1:0] ID_rs1_data_i,
  input  logic [DATA_WIDTH-1:0] ID_rs2_data_i,
  input  logic [DATA_WIDTH-1:0] ID_imm1_i,
  input  logic [DATA_WIDTH-1:0] ID_imm2_i,
  input  logic [DATA_WIDTH-1:0] ID_pc_dest_i,
  input  logic                  ID_mem_wr_en_i,
  input  logic                  ID_mem_rd_en_i,
  input  logic                  ID_memtoreg_i,
  input  logic                  ID_rd_wr_en_i,
  input  logic                  ID_exception_i,
  input  logic [3:0]            ID_mem_op_i,
  input  logic [4:0]            ID_rd_addr_i,
  input  logic [4:0]            ID_rs2_addr_i,
  output logic                  EX_stall_o,
  output logic                  EX_mem_wr_en_o,
  output logic                  EX_mem_rd_en_o,
  output logic                  EX_memtoreg_o,
  output logic                  EX_rd_wr_en_o,
  output logic                  EX_exception_o,
  output logic                  EX_branch_en_o,
  output logic [3:0]            EX_mem_op_o,
  output logic [4:0]            EX_rd_addr_o,
  output logic [4:0]            EX_rs2_addr_o,
  output logic [DATA_WIDTH-1:0] EX_alu_result_o,
  output logic [DATA_WIDTH-1:0] EX_rs2_data_o,
  output logic [DATA_WIDTH-1:0] EX_pc_dest_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_EQ = 4'd10, ALU_PASS_B = 4'd11;

  // Everything that travels from ID/EX to EX/MEM unchanged
  typedef struct packed {
    logic         mem_wr_en;
    logic         mem_rd_en;
    logic         memtoreg;
    logic         rd_wr_en;
    logic         exception;
    logic [3:0]   mem_op;
    logic [4:0]   rd_addr;
    logic [4:0]   rs2_addr;
    logic [W-1:0] rs2_data;
    logic [W-1:0] pc_dest;
  } fields_t;

  logic [W-1:0] alu_result_q, alu_result_d;
  logic         branch_en_q, branch_en_d;
  fields_t      out_q, out_d;

  // Forwarding muxes for both register operands
  logic [W-1:0] rs_data [2];
  logic [1:0]   fwd_sel [2];
  logic [W-1:0] fwd_val [2];
  assign rs_data[0] = ID_rs1_data_i;
  assign rs_data[1] = ID_rs2_data_i;
  assign fwd_sel[0] = forwardA_i;
  assign fwd_sel[1] = forwardB_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_val[gi] = (fwd_sel[gi] == 2'b10) ? alu_result_q :
                         (fwd_sel[gi] == 2'b01) ? WB_rd_wr_data_i : rs_data[gi];
  end

  logic [W-1:0] op1, op2, alu_res;
  logic         branch_taken;
  fields_t      id_fields;
  logic [CW-1:0] shamt;

  // Operand selection, ALU and branch resolution
  always_comb begin
    op1 = ID_alu_source_sel_i[1] ? ID_imm1_i : fwd_val[0];
    op2 = ID_alu_source_sel_i[0] ? ID_imm2_i : fwd_val[1];
    if (ID_jump_en_i) begin
      op1 = ID_imm1_i;
      op2 = W'(4);
    end
    shamt = op2[CW-1:0];
    alu_res = '0;
    case (ID_alu_ctrl_i)
      ALU_ADD:    alu_res = op1 + op2;
      ALU_SUB:    alu_res = op1 - op2;
      ALU_SLL:    alu_res = op1 << shamt;
      ALU_SLT:    alu_res = W'($signed(op1) < $signed(op2));
      ALU_SLTU:   alu_res = W'(op1 < op2);
      ALU_XOR:    alu_res = op1 ^ op2;
      ALU_SRL:    alu_res = op1 >> shamt;
      ALU_SRA:    alu_res = $unsigned($signed(op1) >>> shamt);
      ALU_OR:     alu_res = op1 | op2;
      ALU_AND:    alu_res = op1 & op2;
      ALU_EQ:     alu_res = W'(op1 == op2);
      ALU_PASS_B: alu_res = op2;
      default:    alu_res = '0;
    endcase
    branch_taken = (ID_branch_op_i != 2'b00) && !ID_jump_en_i &&
                   ((alu_res == W'(1)) ^ ID_branch_flag_i);
    id_fields = '{mem_wr_en: ID_mem_wr_en_i, mem_rd_en: ID_mem_rd_en_i,
                  memtoreg: ID_memtoreg_i, rd_wr_en: ID_rd_wr_en_i,
                  exception: ID_exception_i, mem_op: ID_mem_op_i,
                  rd_addr: ID_rd_addr_i, rs2_addr: ID_rs2_addr_i,
                  rs2_data: fwd_val[1], pc_dest: ID_pc_dest_i};
  end

  logic         md_busy;    // issuing or iterating: upstream must hold
  logic         md_done;    // result ready to be written this cycle
  logic [W-1:0] md_result;
  fields_t      md_fields;

  if (MD_ENABLE) begin : g_md
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d;   // MUL: {hi, multiplier}; DIV: {remainder, quotient}
    logic [W-1:0]  opb_q, opb_d;    // multiplicand or divisor magnitude
    logic [2:0]    op_q, op_d;
    logic          neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    fields_t       fields_q, fields_d;

    logic         sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf, issue;
    logic [W-1:0] a_mag, b_mag;
    logic [W:0]   mul_sum, div_shift, div_diff;
    logic [2*W-1:0] prod;
    logic [W-1:0] quo, rem;

    // Issue decode, iteration step and next-state logic
    always_comb begin
      sgn_a = (ID_md_op_i == 3'd1) || (ID_md_op_i == 3'd2) ||
              (ID_md_op_i == 3'd4) || (ID_md_op_i == 3'd6);
      sgn_b = (ID_md_op_i == 3'd1) || (ID_md_op_i == 3'd4) || (ID_md_op_i == 3'd6);
      a_neg = sgn_a && fwd_val[0][W-1];
      b_neg = sgn_b && fwd_val[1][W-1];
      a_mag = a_neg ? -fwd_val[0] : fwd_val[0];
      b_mag = b_neg ? -fwd_val[1] : fwd_val[1];
      div_zero = ID_md_op_i[2] && (fwd_val[1] == '0);
      div_ovf  = ID_md_op_i[2] && !ID_md_op_i[0] &&
                 (fwd_val[0] == MOST_NEG) && (fwd_val[1] == '1);
      issue = (state_q == S_IDLE) && ID_md_en_i && !flush_i;

      mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
      div_diff  = div_shift - {1'b0, opb_q};

      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      op_d      = op_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      fields_d  = fields_q;

      case (state_q)
        S_IDLE: begin
          if (issue) begin
            op_d      = ID_md_op_i;
            fields_d  = id_fields;
            cnt_d     = '0;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            if (div_zero) begin
              // Quotient all-ones, remainder is the raw dividend
              acc_d     = {fwd_val[0], {W{1'b1}}};
              neg_res_d = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = S_DONE;
            end else if (div_ovf) begin
              acc_d     = {{W{1'b0}}, MOST_NEG};
              neg_res_d = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = S_DONE;
            end else if (ID_md_op_i[2]) begin
              acc_d   = {{W{1'b0}}, a_mag};
              opb_d   = b_mag;
              state_d = S_DIV;
            end else begin
              acc_d   = {{W{1'b0}}, b_mag};
              opb_d   = a_mag;
              state_d = S_MUL;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (state_q == S_MUL) begin
            acc_d = {mul_sum, acc_q[W-1:1]};
          end else if (div_diff[W]) begin
            acc_d = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
          end else begin
            acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
      if (flush_i) state_d = S_IDLE;
    end

    // Sign correction and result selection in DONE
    always_comb begin
      prod = neg_res_q ? -acc_q : acc_q;
      quo  = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
      rem  = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
      case (op_q)
        3'd0:                md_result = prod[W-1:0];
        3'd1, 3'd2, 3'd3:    md_result = prod[2*W-1:W];
        3'd4, 3'd5:          md_result = quo;
        default:             md_result = rem;
      endcase
    end

    // Mul/div state and datapath registers
    always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        acc_q     <= '0;
        opb_q     <= '0;
        op_q      <= '0;
        neg_res_q <= 1'b0;
        neg_rem_q <= 1'b0;
        fields_q  <= '0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        acc_q     <= acc_d;
        opb_q     <= opb_d;
        op_q      <= op_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
        fields_q  <= fields_d;
      end
    end

    assign md_busy   = ((state_q == S_IDLE) && ID_md_en_i) ||
                       (state_q == S_MUL) || (state_q == S_DIV);
    assign md_done   = (state_q == S_DONE);
    assign md_fields = fields_q;
  end else begin : g_no_md
    assign md_busy   = 1'b0;
    assign md_done   = 1'b0;
    assign md_result = '0;
    assign md_fields = '0;
  end

  assign EX_stall_o = resetn_i && !flush_i && md_busy;

  // EX/MEM register next values: flush, M result, bubble or normal ALU op
  always_comb begin
    out_d        = out_q;
    alu_result_d = alu_result_q;
    branch_en_d  = branch_en_q;
    if (flush_i || (md_busy && !md_done)) begin
      out_d.mem_wr_en = 1'b0;
      out_d.mem_rd_en = 1'b0;
      out_d.memtoreg  = 1'b0;
      out_d.rd_wr_en  = 1'b0;
      out_d.exception = 1'b0;
      branch_en_d     = 1'b0;
      if (flush_i) alu_result_d = '0;
    end else if (md_done) begin
      out_d        = md_fields;
      alu_result_d = md_result;
      branch_en_d  = 1'b0;
    end else begin
      out_d        = id_fields;
      alu_result_d = alu_res;
      branch_en_d  = branch_taken;
      // Only reachable without the mul/div unit: M op becomes an exception
      if (ID_md_en_i) begin
        out_d.exception = 1'b1;
        out_d.rd_wr_en  = 1'b0;
        branch_en_d     = 1'b0;
      end
    end
  end

  // EX/MEM pipeline register; reset clears everything including pc_dest
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      out_q        <= '0;
      alu_result_q <= '0;
      branch_en_q  <= 1'b0;
    end else begin
      out_q        <= out_d;
      alu_result_q <= alu_result_d;
      branch_en_q  <= branch_en_d;
    end
  end

  assign EX_mem_wr_en_o  = out_q.mem_wr_en;
  assign EX_mem_rd_en_o  = out_q.mem_rd_en;
  assign EX_memtoreg_o   = out_q.memtoreg;
  assign EX_rd_wr_en_o   = out_q.rd_wr_en;
  assign EX_exception_o  = out_q.exception;
  assign EX_branch_en_o  = branch_en_q;
  assign EX_mem_op_o     = out_q.mem_op;
  assign EX_rd_addr_o    = out_q.rd_addr;
  assign EX_rs2_addr_o   = out_q.rs2_addr;
  assign EX_alu_result_o = alu_result_q;
  assign EX_rs2_data_o   = out_q.rs2_data;
  assign EX_pc_dest_o    = out_q.pc_dest;

endmodule
